// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage operand forwarding select and load-use stall controller
module fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_id_valid,
  input  logic [RA_W-1:0]  i_id_rs1,
  input  logic [RA_W-1:0]  i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [RA_W-1:0]  i_id_rd,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic             i_flush,
  output logic [1:0]       o_sel_a,
  output logic [1:0]       o_sel_b,
  output logic             o_ex_valid,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  // In-flight producer records. The WB stage only ever consumes a record
  // and never forwards from it here, so only EX and MEM are kept.
  logic            r_ex_valid;
  logic [RA_W-1:0] r_ex_rd;
  logic            r_ex_regwrite;
  logic            r_ex_memread;

  logic            r_mem_valid;
  logic [RA_W-1:0] r_mem_rd;
  logic            r_mem_regwrite;

  logic [1:0]       r_sel_a;
  logic [1:0]       r_sel_b;
  logic [CNT_W-1:0] r_stall_count;

  logic       w_ex_match_a;
  logic       w_ex_match_b;
  logic       w_mem_match_a;
  logic       w_mem_match_b;
  logic       w_hazard;
  logic       w_stall;
  logic       w_advance;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  // A producer feeds a source only if it really writes that register and
  // the source is actually read; x0 never forwards.
  function automatic logic producer_match(
    input logic            p_valid,
    input logic            p_regwrite,
    input logic [RA_W-1:0] p_rd,
    input logic [RA_W-1:0] src,
    input logic            use_src
  );
    return p_valid && p_regwrite && (p_rd == src) && (src != '0) && use_src;
  endfunction

  // Source matches against the pre-edge EX and MEM records.
  always_comb begin
    w_ex_match_a  = producer_match(r_ex_valid,  r_ex_regwrite,  r_ex_rd,  i_id_rs1, i_id_use_rs1);
    w_ex_match_b  = producer_match(r_ex_valid,  r_ex_regwrite,  r_ex_rd,  i_id_rs2, i_id_use_rs2);
    w_mem_match_a = producer_match(r_mem_valid, r_mem_regwrite, r_mem_rd, i_id_rs1, i_id_use_rs1);
    w_mem_match_b = producer_match(r_mem_valid, r_mem_regwrite, r_mem_rd, i_id_rs2, i_id_use_rs2);
  end

  // Load-use hazard: a load in EX cannot supply its data until it reaches
  // WB, so a dependent instruction in ID waits one cycle. Flush wins.
  always_comb begin
    w_hazard  = i_id_valid && r_ex_valid && r_ex_memread && (w_ex_match_a || w_ex_match_b);
    w_stall   = w_hazard && !i_flush;
    w_advance = i_id_valid && !w_stall && !i_flush;
  end

  // Nearest producer wins: EX (moving to MEM, ALU result path) before MEM
  // (moving to WB, writeback path).
  always_comb begin
    w_sel_a = SEL_RF;
    w_sel_b = SEL_RF;
    if (w_ex_match_a) begin
      w_sel_a = SEL_ALU;
    end else if (w_mem_match_a) begin
      w_sel_a = SEL_WB;
    end
    if (w_ex_match_b) begin
      w_sel_b = SEL_ALU;
    end else if (w_mem_match_b) begin
      w_sel_b = SEL_WB;
    end
  end

  // Advance the record pipeline; a stalled, flushed or empty ID slot puts a
  // bubble into EX with the operand selects parked at the regfile.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_sel_a        <= SEL_RF;
      r_sel_b        <= SEL_RF;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_advance) begin
        r_ex_valid    <= 1'b1;
        r_ex_rd       <= i_id_rd;
        r_ex_regwrite <= i_id_regwrite;
        r_ex_memread  <= i_id_memread;
        r_sel_a       <= w_sel_a;
        r_sel_b       <= w_sel_b;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_sel_a       <= SEL_RF;
        r_sel_b       <= SEL_RF;
      end
    end
  end

  // Count stall cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_sel_a       = r_sel_a;
  assign o_sel_b       = r_sel_b;
  assign o_ex_valid    = r_ex_valid;
  assign o_stall       = w_stall;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - randomized and directed check of fwd_hazard_ctrl against an in-flight instruction model
module tb_fwd_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [RA_W-1:0]  id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic             ex_valid;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  fwd_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .i_id_rd       (id_rd),
    .i_id_regwrite (id_regwrite),
    .i_id_memread  (id_memread),
    .i_flush       (flush),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_ex_valid    (ex_valid),
    .o_stall       (stall),
    .o_stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  // flight[0] is the instruction now in EX, flight[1] the one in MEM.
  instr_t flight[$];
  int     exp_sel_a;
  int     exp_sel_b;
  int     exp_ex_valid;
  int     exp_count;
  int     passed;
  int     total;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.v = 0; b.rs1 = 0; b.rs2 = 0; b.u1 = 0; b.u2 = 0;
    b.rd = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  function automatic instr_t mk(input bit v, input int rs1, input int rs2, input bit u1,
                                input bit u2, input int rd, input bit rw, input bit mr);
    instr_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  function automatic bit writes(input instr_t p, input int r);
    return p.v && p.rw && (p.rd == r) && (r != 0);
  endfunction

  // Operand source for a register read: 2 if the producer is one stage
  // ahead (ALU result), 1 if two stages ahead (writeback), else regfile.
  function automatic int fwd_sel(input int src, input bit use_src);
    if (!use_src) return 0;
    for (int k = 0; k < 2; k++) begin
      if (writes(flight[k], src)) return (k == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic bit load_use(input instr_t id);
    instr_t ex;
    ex = flight[0];
    if (!id.v || !ex.v || !ex.mr) return 0;
    return (id.u1 && writes(ex, id.rs1)) || (id.u2 && writes(ex, id.rs2));
  endfunction

  task automatic model_reset();
    flight.delete();
    flight.push_back(bubble());
    flight.push_back(bubble());
    exp_sel_a    = 0;
    exp_sel_b    = 0;
    exp_ex_valid = 0;
    exp_count    = 0;
  endtask

  // One clock cycle: check registered outputs, present ID, check stall,
  // then advance the model to match the coming clock edge.
  task automatic cycle(input instr_t id, input bit fl, input bit rst, output bit m_stall);
    @(negedge clk);
    check_val("sel_a", int'(sel_a), exp_sel_a);
    check_val("sel_b", int'(sel_b), exp_sel_b);
    check_val("ex_valid", int'(ex_valid), exp_ex_valid);
    check_val("stall_count", int'(stall_count), exp_count);
    reset       = rst;
    id_valid    = id.v;
    id_rs1      = RA_W'(id.rs1);
    id_rs2      = RA_W'(id.rs2);
    id_use_rs1  = id.u1;
    id_use_rs2  = id.u2;
    id_rd       = RA_W'(id.rd);
    id_regwrite = id.rw;
    id_memread  = id.mr;
    flush       = fl;
    #1;
    m_stall = load_use(id) && !fl;
    if (rst) begin
      model_reset();
    end else begin
      check_val("stall", int'(stall), int'(m_stall));
      if (m_stall && exp_count < CNT_MAX) exp_count++;
      if (id.v && !m_stall && !fl) begin
        exp_sel_a    = fwd_sel(id.rs1, id.u1);
        exp_sel_b    = fwd_sel(id.rs2, id.u2);
        exp_ex_valid = 1;
        flight.push_front(id);
      end else begin
        exp_sel_a    = 0;
        exp_sel_b    = 0;
        exp_ex_valid = 0;
        flight.push_front(bubble());
      end
      void'(flight.pop_back());
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  instr_t nop;
  instr_t cur;
  bit     st;
  bit     prev_st;
  int     cnt0;

  initial begin
    passed = 0;
    total  = 0;
    nop    = bubble();
    reset = 1'b1; id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0;
    id_use_rs2 = 0; id_rd = '0; id_regwrite = 0; id_memread = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_sel_a", int'(sel_a), 0);
    check_val("reset_ex_valid", int'(ex_valid), 0);
    check_val("reset_count", int'(stall_count), 0);

    // add x5 followed immediately by a reader of x5: ALU path, no stall
    cycle(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0, st);
    cycle(mk(1, 5, 6, 1, 1, 8, 1, 0), 0, 0, st);
    check_val("t1_stall", int'(stall), 0);
    after_edge();
    check_val("t1_sel_a", int'(sel_a), 2);

    // add x5, unrelated, reader of x5 on rs2: writeback path
    cycle(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0, st);
    cycle(mk(1, 9, 10, 1, 1, 11, 1, 0), 0, 0, st);
    cycle(mk(1, 12, 5, 1, 1, 13, 1, 0), 0, 0, st);
    after_edge();
    check_val("t2_sel_b", int'(sel_b), 1);
    check_val("t2_sel_a", int'(sel_a), 0);

    // load x7 then a double reader of x7: one stall, bubble, then WB path
    cnt0 = int'(stall_count);
    cycle(mk(1, 1, 2, 1, 0, 7, 1, 1), 0, 0, st);
    cycle(mk(1, 7, 7, 1, 1, 14, 1, 0), 0, 0, st);
    check_val("t3_stall", int'(stall), 1);
    after_edge();
    check_val("t3_bubble", int'(ex_valid), 0);
    check_val("t3_count", int'(stall_count), cnt0 + 1);
    cycle(mk(1, 7, 7, 1, 1, 14, 1, 0), 0, 0, st);
    check_val("t3_nostall", int'(stall), 0);
    after_edge();
    check_val("t3_sel_a", int'(sel_a), 1);
    check_val("t3_sel_b", int'(sel_b), 1);

    // x0 never forwards and a load to x0 never stalls
    cycle(mk(1, 1, 2, 1, 1, 0, 1, 0), 0, 0, st);
    cycle(mk(1, 0, 3, 1, 1, 15, 1, 0), 0, 0, st);
    after_edge();
    check_val("t4_sel_a", int'(sel_a), 0);
    cycle(mk(1, 1, 2, 1, 1, 0, 1, 1), 0, 0, st);
    cycle(mk(1, 0, 0, 1, 1, 15, 1, 0), 0, 0, st);
    check_val("t4_nostall", int'(stall), 0);

    // load x3 then a reader under flush: no stall, bubble, count held
    cnt0 = int'(stall_count);
    cycle(mk(1, 1, 2, 1, 1, 3, 1, 1), 0, 0, st);
    cycle(mk(1, 3, 4, 1, 1, 16, 1, 0), 1, 0, st);
    check_val("t5_stall", int'(stall), 0);
    after_edge();
    check_val("t5_bubble", int'(ex_valid), 0);
    check_val("t5_count", int'(stall_count), cnt0);

    // reset during a load-use stall
    cycle(mk(1, 1, 2, 1, 1, 7, 1, 1), 0, 0, st);
    cycle(mk(1, 7, 2, 1, 1, 14, 1, 0), 0, 1, st);
    after_edge();
    check_val("t6_stall", int'(stall), 0);
    check_val("t6_ex_valid", int'(ex_valid), 0);
    check_val("t6_sel_a", int'(sel_a), 0);
    check_val("t6_count", int'(stall_count), 0);
    cycle(mk(1, 7, 2, 1, 1, 14, 1, 0), 0, 0, st);

    // drive the counter past its top: 2^CNT_W + 5 stalls
    for (int i = 0; i < CNT_MAX + 6; i++) begin
      cycle(mk(1, 1, 2, 1, 1, 3, 1, 1), 0, 0, st);
      cycle(mk(1, 3, 2, 1, 1, 4, 1, 0), 0, 0, st);
    end
    after_edge();
    check_val("sat_count", int'(stall_count), CNT_MAX);

    // random traffic over a small register window; a stalled ID is re-presented
    prev_st = 0;
    cur = nop;
    for (int i = 0; i < 3000; i++) begin
      if (!prev_st) begin
        cur = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      cycle(cur, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0, st);
      prev_st = st;
    end
    cycle(nop, 0, 0, st);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
